// File: rtl/drum_pkg.sv
// Shared definitions for the step sequencer: geometry, FSM encoding and
// the step-resolution filter used when gating voice triggers.
package drum_pkg;

  localparam int NSTEP  = 16;
  localparam int NVOICE = 5;
  localparam int STEP_W = 4;

  localparam logic [1:0] TEMPO_MAX = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PLAY = 2'd1,
    ST_HOLD = 2'd2
  } seq_state_t;

  // Fourths wins over Eighths; with neither selected every step may sound.
  function automatic logic step_allowed(input logic [STEP_W-1:0] step,
                                        input logic              fourths,
                                        input logic              eighths);
    if (fourths) begin
      return (step[1:0] == 2'b00);
    end else if (eighths) begin
      return (step[0] == 1'b0);
    end else begin
      return 1'b1;
    end
  endfunction

endpackage

// File: rtl/step_timer.sv
// Per-step down-counter: reloads 2^(BASE_W+tempo)-1 on step entry, counts
// while run is high, and flags terminal count plus the first half of a step.
module step_timer
  import drum_pkg::*;
#(
  parameter int         BASE_W    = 22,
  parameter logic [1:0] TEMPO_RST = 2'd1
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic       clear,
  input  logic       load,
  input  logic [1:0] tempo,
  input  logic       run,
  output logic       tc,
  output logic       first_half_next
);

  localparam int            CW  = BASE_W + int'(TEMPO_MAX);
  localparam logic [CW-1:0] ONE = {{(CW-1){1'b0}}, 1'b1};

  logic [CW-1:0] count_reg;
  logic [CW-1:0] count_next;
  logic [1:0]    shift_reg;
  logic [1:0]    shift_next;
  logic [CW-1:0] half_mask;

  // The tempo is captured at load so a change mid-step cannot stretch it.
  always_comb begin
    shift_next = load ? tempo : shift_reg;
    count_next = count_reg;
    if (clear) begin
      count_next = '0;
    end else if (load) begin
      count_next = (ONE << (BASE_W + int'(tempo))) - ONE;
    end else if (run && (count_reg != '0)) begin
      count_next = count_reg - ONE;
    end
  end

  assign tc              = run && (count_reg == '0);
  assign half_mask       = ONE << (BASE_W - 1 + int'(shift_next));
  assign first_half_next = |(count_next & half_mask);

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      count_reg <= '0;
      shift_reg <= TEMPO_RST;
    end else begin
      count_reg <= count_next;
      shift_reg <= shift_next;
    end
  end

endmodule

// File: rtl/step_seq_ctrl.sv
// 16-step, 5-voice drum sequencer: transport FSM, tempo control, pattern
// recording and gated voice trigger generation.
module step_seq_ctrl
  import drum_pkg::*;
#(
  parameter int         BASE_W    = 22,
  parameter logic [1:0] TEMPO_RST = 2'd1
) (
  input  logic                    Clk,
  input  logic                    Reset_n,
  input  logic                    Start,
  input  logic                    Stop,
  input  logic                    Tempo_up,
  input  logic                    Tempo_dn,
  input  logic                    Tempo_rst,
  input  logic                    Fourths,
  input  logic                    Eighths,
  input  logic                    Rec,
  input  logic [NVOICE-1:0]       Voice_in,
  input  logic                    Clr,
  output logic [STEP_W-1:0]       Step,
  output logic                    Step_tick,
  output logic [NVOICE-1:0]       Voice_out,
  output logic                    Playing,
  output logic [1:0]              Tempo,
  output logic [NSTEP*NVOICE-1:0] Pattern
);

  seq_state_t        state_reg;
  seq_state_t        state_next;
  logic [STEP_W-1:0] step_reg;
  logic [STEP_W-1:0] step_next;
  logic              tick_reg;
  logic              tick_next;
  logic [1:0]        tempo_reg;
  logic [1:0]        tempo_next;
  logic [NVOICE-1:0] voice_reg;
  logic [NVOICE-1:0] voice_next;
  logic [NVOICE-1:0] col_reg;
  logic [NVOICE-1:0] col_next;
  logic [NVOICE-1:0] entry_col;

  logic timer_load;
  logic timer_clear;
  logic timer_run;
  logic timer_tc;
  logic first_half_next;
  logic col_load;

  step_timer #(
    .BASE_W    (BASE_W),
    .TEMPO_RST (TEMPO_RST)
  ) u_step_timer (
    .Clk             (Clk),
    .Reset_n         (Reset_n),
    .clear           (timer_clear),
    .load            (timer_load),
    .tempo           (tempo_reg),
    .run             (timer_run),
    .tc              (timer_tc),
    .first_half_next (first_half_next)
  );

  always_comb begin
    tempo_next = tempo_reg;
    if (Tempo_rst) begin
      tempo_next = TEMPO_RST;
    end else if (Tempo_up && !Tempo_dn) begin
      if (tempo_reg != 2'd0) begin
        tempo_next = tempo_reg - 2'd1;
      end
    end else if (Tempo_dn && !Tempo_up) begin
      if (tempo_reg != TEMPO_MAX) begin
        tempo_next = tempo_reg + 2'd1;
      end
    end
  end

  // Stop is tested first in every state so it always beats a coincident Start.
  always_comb begin
    state_next  = state_reg;
    step_next   = step_reg;
    tick_next   = 1'b0;
    timer_load  = 1'b0;
    timer_clear = 1'b0;
    timer_run   = 1'b0;
    col_load    = 1'b0;
    unique case (state_reg)
      ST_IDLE: begin
        if (Start && !Stop) begin
          state_next = ST_PLAY;
          step_next  = '0;
          tick_next  = 1'b1;
          timer_load = 1'b1;
          col_load   = 1'b1;
        end
      end
      ST_PLAY: begin
        if (Stop) begin
          state_next = ST_HOLD;
        end else begin
          timer_run = 1'b1;
          if (timer_tc) begin
            step_next  = step_reg + 1'b1;
            tick_next  = 1'b1;
            timer_load = 1'b1;
            col_load   = 1'b1;
          end
        end
      end
      ST_HOLD: begin
        if (Stop) begin
          state_next  = ST_IDLE;
          step_next   = '0;
          timer_clear = 1'b1;
        end else if (Start) begin
          state_next = ST_PLAY;
        end
      end
      default: begin
        state_next  = ST_IDLE;
        step_next   = '0;
        timer_clear = 1'b1;
      end
    endcase
  end

  // The column is latched on step entry, before any record write lands, so a
  // step being recorded still sounds its previous contents this loop.
  always_comb begin
    col_next   = col_load ? entry_col : col_reg;
    voice_next = '0;
    if ((state_next == ST_PLAY) && first_half_next &&
        step_allowed(step_next, Fourths, Eighths)) begin
      voice_next = col_next;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NVOICE; gi++) begin : g_voice
      logic [NSTEP-1:0] lane_reg;

      always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
          lane_reg <= '0;
        end else if ((state_reg == ST_IDLE) && Clr) begin
          lane_reg <= '0;
        end else if (Rec && tick_reg) begin
          lane_reg[step_reg] <= Voice_in[gi];
        end
      end

      assign Pattern[gi*NSTEP +: NSTEP] = lane_reg;
      assign entry_col[gi]              = lane_reg[step_next];
    end
  endgenerate

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_reg <= ST_IDLE;
      step_reg  <= '0;
      tick_reg  <= 1'b0;
      tempo_reg <= TEMPO_RST;
      voice_reg <= '0;
      col_reg   <= '0;
    end else begin
      state_reg <= state_next;
      step_reg  <= step_next;
      tick_reg  <= tick_next;
      tempo_reg <= tempo_next;
      voice_reg <= voice_next;
      col_reg   <= col_next;
    end
  end

  assign Step      = step_reg;
  assign Step_tick = tick_reg;
  assign Voice_out = voice_reg;
  assign Playing   = (state_reg == ST_PLAY);
  assign Tempo     = tempo_reg;

endmodule

// File: tb/tb_step_seq_ctrl.sv
// Directed + randomized bench for step_seq_ctrl with a cycle-level model that
// tracks elapsed cycles per step and the pattern as a plain bit array.
module tb_step_seq_ctrl;
  import drum_pkg::*;

  localparam int BASE_W = 3;

  logic        Clk = 1'b0;
  logic        Reset_n = 1'b0;
  logic        Start = 1'b0;
  logic        Stop = 1'b0;
  logic        Tempo_up = 1'b0;
  logic        Tempo_dn = 1'b0;
  logic        Tempo_rst = 1'b0;
  logic        Fourths = 1'b0;
  logic        Eighths = 1'b0;
  logic        Rec = 1'b0;
  logic [4:0]  Voice_in = 5'd0;
  logic        Clr = 1'b0;
  logic [3:0]  Step;
  logic        Step_tick;
  logic [4:0]  Voice_out;
  logic        Playing;
  logic [1:0]  Tempo;
  logic [79:0] Pattern;

  always #5 Clk = ~Clk;

  step_seq_ctrl #(
    .BASE_W    (BASE_W),
    .TEMPO_RST (2'd1)
  ) dut (
    .Clk       (Clk),
    .Reset_n   (Reset_n),
    .Start     (Start),
    .Stop      (Stop),
    .Tempo_up  (Tempo_up),
    .Tempo_dn  (Tempo_dn),
    .Tempo_rst (Tempo_rst),
    .Fourths   (Fourths),
    .Eighths   (Eighths),
    .Rec       (Rec),
    .Voice_in  (Voice_in),
    .Clr       (Clr),
    .Step      (Step),
    .Step_tick (Step_tick),
    .Voice_out (Voice_out),
    .Playing   (Playing),
    .Tempo     (Tempo),
    .Pattern   (Pattern)
  );

  // Reference model: mode 0 idle, 1 playing, 2 paused.
  int        m_mode;
  int        m_step;
  int        m_elapsed;
  int        m_period;
  int        m_tempo;
  bit        m_tick;
  bit [4:0]  m_voice;
  bit [4:0]  m_col;
  bit [15:0] m_pat [5];

  int n_cmp  = 0;
  int n_fail = 0;

  function automatic int period_of(int t);
    return 1 << (BASE_W + t);
  endfunction

  function automatic bit [4:0] col_of(int s);
    bit [4:0] c;
    for (int v = 0; v < 5; v++) c[v] = m_pat[v][s];
    return c;
  endfunction

  function automatic bit [79:0] pat_vec();
    bit [79:0] p;
    for (int v = 0; v < 5; v++) p[v*16 +: 16] = m_pat[v];
    return p;
  endfunction

  task automatic model_reset();
    m_mode = 0; m_step = 0; m_elapsed = 0; m_tempo = 1;
    m_period = period_of(1); m_tick = 0; m_voice = '0; m_col = '0;
    for (int v = 0; v < 5; v++) m_pat[v] = '0;
  endtask

  task automatic enter_step(int s, int t);
    m_step = s; m_elapsed = 0; m_period = period_of(t);
    m_tick = 1; m_col = col_of(s);
  endtask

  task automatic model_edge();
    int  old_mode;
    int  old_step;
    int  old_tempo;
    bit  old_tick;
    bit  allowed;
    if (!Reset_n) begin
      model_reset();
      return;
    end
    old_mode = m_mode; old_step = m_step; old_tempo = m_tempo; old_tick = m_tick;
    m_tick = 0;
    case (old_mode)
      0: if (Start && !Stop) begin m_mode = 1; enter_step(0, old_tempo); end
      1: if (Stop) m_mode = 2;
         else begin
           m_elapsed++;
           if (m_elapsed == m_period) enter_step((m_step + 1) % 16, old_tempo);
         end
      default: if (Stop) begin m_mode = 0; m_step = 0; m_elapsed = 0; end
               else if (Start) m_mode = 1;
    endcase
    if (Rec && old_tick)
      for (int v = 0; v < 5; v++) m_pat[v][old_step] = Voice_in[v];
    if (old_mode == 0 && Clr)
      for (int v = 0; v < 5; v++) m_pat[v] = '0;
    if (Tempo_rst) m_tempo = 1;
    else if (Tempo_up && !Tempo_dn) m_tempo = (m_tempo > 0) ? m_tempo - 1 : 0;
    else if (Tempo_dn && !Tempo_up) m_tempo = (m_tempo < 3) ? m_tempo + 1 : 3;
    allowed = Fourths ? (m_step % 4 == 0) : Eighths ? (m_step % 2 == 0) : 1'b1;
    m_voice = (m_mode == 1 && m_elapsed < m_period / 2 && allowed) ? m_col : 5'd0;
  endtask

  task automatic chk(string tag, logic [79:0] obs, logic [79:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("step",    80'(Step),      80'(m_step));
    chk("tick",    80'(Step_tick), 80'(m_tick));
    chk("voice",   80'(Voice_out), 80'(m_voice));
    chk("playing", 80'(Playing),   80'(m_mode == 1));
    chk("tempo",   80'(Tempo),     80'(m_tempo));
    chk("pattern", Pattern,        pat_vec());
  endtask

  task automatic cycle();
    @(posedge Clk);
    model_edge();
    @(negedge Clk);
    check_all();
  endtask

  initial begin
    int        hi;
    int        n;
    bit        found;
    bit [79:0] exp_pat;

    model_reset();
    repeat (3) cycle();
    Reset_n = 1'b1;
    cycle();

    // Free-running playback: one tick per 16 cycles, wrapping 15 -> 0.
    Start = 1; cycle(); Start = 0;
    repeat (16 * 17) cycle();
    Stop = 1; cycle(); cycle(); Stop = 0;
    chk("idle_step", 80'(Step), 80'(0));

    // Record voice A on step 0 only; first loop still hears the old column.
    Clr = 1; cycle(); Clr = 0;
    Start = 1; cycle(); Start = 0;
    hi = int'(Voice_out[0]);
    Rec = 1; Voice_in = 5'b00001; cycle(); Rec = 0; Voice_in = '0;
    hi += int'(Voice_out[0]);
    repeat (254) begin cycle(); hi += int'(Voice_out[0]); end
    chk("voiceA_prewrite", 80'(hi), 80'(0));
    chk("patA", Pattern, 80'h1);
    hi = 0;
    repeat (256) begin cycle(); hi += int'(Voice_out[0]); end
    chk("voiceA_hi_cycles", 80'(hi), 80'(8));

    // Random pattern, played under each resolution setting.
    Stop = 1; cycle(); cycle(); Stop = 0;
    Clr = 1; cycle(); Clr = 0;
    Start = 1; cycle(); Start = 0;
    Rec = 1;
    repeat (256) begin Voice_in = 5'($urandom); cycle(); end
    Rec = 0; Voice_in = '0;
    for (int m = 0; m < 3; m++) begin
      Fourths = (m == 0); Eighths = (m == 1);
      repeat (256) cycle();
    end
    Fourths = 0; Eighths = 0;

    // Tempo: dual pulse is a no-op, then speed up twice (saturating at 0).
    Tempo_up = 1; Tempo_dn = 1; cycle(); Tempo_up = 0; Tempo_dn = 0;
    chk("tempo_dual", 80'(Tempo), 80'(1));
    Tempo_up = 1; cycle(); Tempo_up = 0;
    chk("tempo_up1", 80'(Tempo), 80'(0));
    Tempo_up = 1; cycle(); Tempo_up = 0;
    chk("tempo_up2", 80'(Tempo), 80'(0));
    n = 0;
    do begin cycle(); n++; end while (!Step_tick && n < 64);
    chk("tick_seen", 80'(Step_tick), 80'(1));
    n = 0;
    do begin cycle(); n++; end while (!Step_tick && n < 64);
    chk("period_fast", 80'(n), 80'(8));
    repeat (5) begin Tempo_dn = 1; cycle(); Tempo_dn = 0; end
    chk("tempo_sat_hi", 80'(Tempo), 80'(3));
    Tempo_rst = 1; Tempo_up = 1; cycle(); Tempo_rst = 0; Tempo_up = 0;
    chk("tempo_rst_prio", 80'(Tempo), 80'(1));
    repeat (300) cycle();

    // Pause mid step 5 for 100 cycles, resume with the remaining count.
    found = 0;
    for (int i = 0; i < 1200 && !found; i++) begin
      cycle();
      found = Step_tick && (Step == 4'd5);
    end
    chk("reach_step5", 80'(Step), 80'(5));
    repeat (6) cycle();
    Stop = 1; cycle(); Stop = 0;
    repeat (100) cycle();
    chk("hold_step", 80'(Step), 80'(5));
    chk("hold_playing", 80'(Playing), 80'(0));
    Start = 1; cycle(); Start = 0;
    n = 0;
    do begin cycle(); n++; end while (Step == 4'd5 && n < 64);
    chk("resume_remaining", 80'(n), 80'(10));
    Stop = 1; cycle(); cycle(); Stop = 0;
    chk("stop_to_idle_step", 80'(Step), 80'(0));
    chk("stop_to_idle_play", 80'(Playing), 80'(0));

    // Record voices A and E on every step for one loop.
    Clr = 1; cycle(); Clr = 0;
    Start = 1; cycle(); Start = 0;
    Rec = 1; Voice_in = 5'b10001;
    repeat (256) cycle();
    Rec = 0; Voice_in = '0;
    exp_pat = '0;
    exp_pat[15:0]  = 16'hFFFF;
    exp_pat[79:64] = 16'hFFFF;
    chk("rec_AE", Pattern, exp_pat);
    Clr = 1; cycle(); Clr = 0;
    chk("clr_ignored_play", Pattern, exp_pat);

    // Randomized control traffic.
    for (int i = 0; i < 1500; i++) begin
      Start     = ($urandom_range(39) == 0);
      Stop      = ($urandom_range(59) == 0);
      Tempo_up  = ($urandom_range(49) == 0);
      Tempo_dn  = ($urandom_range(49) == 0);
      Tempo_rst = ($urandom_range(149) == 0);
      Clr       = ($urandom_range(29) == 0);
      Rec       = 1'($urandom);
      Voice_in  = 5'($urandom);
      if ($urandom_range(99) == 0) Fourths = 1'($urandom);
      if ($urandom_range(99) == 0) Eighths = 1'($urandom);
      cycle();
    end
    Start = 0; Stop = 0; Tempo_up = 0; Tempo_dn = 0; Tempo_rst = 0;
    Clr = 0; Rec = 0; Voice_in = '0;

    // Asynchronous reset in the middle of playback.
    Start = 1; cycle(); Start = 0;
    repeat (37) cycle();
    Reset_n = 1'b0;
    #1;
    model_reset();
    check_all();
    chk("async_rst_pattern", Pattern, 80'h0);
    repeat (2) cycle();
    Reset_n = 1'b1;
    n = 0;
    repeat (40) begin cycle(); n += int'(Step_tick); end
    chk("no_tick_after_rst", 80'(n), 80'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/step_seq_ctrl.md
STEP_SEQ_CTRL -- requirements
Module: step_seq_ctrl

Interface
REQ-001 SHALL have parameter BASE_W, default 22, log2 of step period in Clk cycles at tempo 0.
REQ-002 SHALL have parameter TEMPO_RST, default 2'd1, tempo index loaded by reset and Tempo_rst.
REQ-003 SHALL have port Clk  in  1  system clock, all logic rising-edge.
REQ-004 SHALL have port Reset_n  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have port Start  in  1  single-cycle pulse, begin/resume playback.
REQ-006 SHALL have port Stop  in  1  single-cycle pulse, pause/stop playback.
REQ-007 SHALL have ports Tempo_up, Tempo_dn, Tempo_rst  in  1 each  single-cycle pulses.
REQ-008 SHALL have ports Fourths, Eighths  in  1 each  resolution select.
REQ-009 SHALL have port Rec  in  1  record enable.
REQ-010 SHALL have port Voice_in  in  5  live voice switches, bit0 = voice A.
REQ-011 SHALL have port Clr  in  1  pulse, clear all patterns.
REQ-012 SHALL have port Step  out  4  current step index 0..15.
REQ-013 SHALL have port Step_tick  out  1  one-cycle pulse on each step entry.
REQ-014 SHALL have port Voice_out  out  5  gated voice triggers.
REQ-015 SHALL have port Playing  out  1  high in PLAY.
REQ-016 SHALL have port Tempo  out  2  current tempo index.
REQ-017 SHALL have port Pattern  out  80  voice v at bits [16v+15:16v], bit s = step s.

Function
REQ-018 SHALL implement FSM IDLE, PLAY, HOLD.
- IDLE + Start -> PLAY, Step=0.
- PLAY + Stop -> HOLD, Step kept.
- HOLD + Start -> PLAY, Step kept.
- HOLD + Stop -> IDLE, Step=0.
REQ-019 SHALL give Stop priority over Start when both are asserted in the same cycle.
REQ-020 SHALL assert Step_tick in the first cycle of every step, including PLAY entry.
REQ-021 SHALL hold each step for exactly P = 2^(BASE_W+Tempo) cycles, then advance Step modulo 16 (15 -> 0 wraps).
REQ-022 SHALL make Tempo_up decrement Tempo (faster) and Tempo_dn increment it, each saturating within 0..3.
REQ-023 SHALL give Tempo_rst priority over Tempo_up/Tempo_dn; simultaneous up+dn SHALL cause no change.
REQ-024 SHALL apply a tempo change to the period starting at the next step boundary; the current step completes at the old P.
REQ-025 SHALL drive Voice_out[v] = Pattern bit(v, Step) AND step-allowed AND first-half, registered and aligned with Step.
- First-half: high for the first P/2 cycles of the step.
- Step-allowed: Fourths=1 -> Step%4==0; else Eighths=1 -> Step%2==0; else all steps.
REQ-026 SHALL hold Voice_out at 0 outside PLAY; in HOLD the step counter SHALL freeze and resume with the remaining count.
REQ-027 SHALL, when Rec=1 and Step_tick=1, write Voice_in into the Pattern column for Step; the written value SHALL appear on Pattern next cycle.
REQ-028 SHALL drive Voice_out for a step being recorded from the pre-write pattern; the new value is heard on the next loop.
REQ-029 SHALL honour Clr only in IDLE (all 80 bits -> 0 next cycle) and ignore it in PLAY/HOLD.

Reset
REQ-030 SHALL, while Reset_n=0, force state IDLE, Step=0, Step_tick=0, Voice_out=0, Playing=0, Tempo=TEMPO_RST, Pattern=0, period counter=0.
REQ-031 SHALL fully restore the reset state on assertion mid-playback, with no residual tick after release.

Structure
REQ-032 SHALL place FSM state encoding, NSTEP=16 and NVOICE=5 in shared package drum_pkg.
REQ-033 SHALL contain one sub-module, step_timer: loadable down-counter with tempo-shifted reload, freeze input and terminal-count pulse.

Verification
REQ-034 SHALL run the bench with BASE_W=3, so P=16 cycles at tempo 1.
REQ-035 Start in IDLE -> Step_tick every 16 cycles; Step 0,1,...,15,0; Playing=1.
REQ-036 Pattern voice A = 16'h0001, no Fourths/Eighths -> Voice_out[0] high 8 cycles at Step 0 only.
REQ-037 Tempo_up and Tempo_dn asserted together, then Tempo_up twice from tempo 1 -> Tempo 1 after the dual pulse, 0 after the first Tempo_up, 0 after the second (saturates); period 8 from the next step.
REQ-038 Stop at step 5 mid-step, wait 100 cycles, Start -> Step 5 resumes with the remaining count; second Stop from HOLD -> IDLE, Step=0.
REQ-039 Rec=1 with Voice_in=5'b10001 for one loop -> Pattern = all ones for voices A and E; Reset_n low mid-loop -> all outputs at reset values.
